// File: rtl/case_conv_ctrl.sv
// rtl/case_conv_ctrl.sv - UART case-converting byte FIFO with TX launch FSM.
// Optional CR->CRLF expansion when CASE_CONV_CRLF_EN is defined.
module case_conv_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [7:0]               i_rx_data,
  input  logic                     i_rx_valid,
  input  logic [1:0]               i_mode,
  input  logic                     i_tx_busy,
  input  logic                     i_clr_ovf,
  output logic [7:0]               o_tx_data,
  output logic                     o_tx_start,
  output logic [$clog2(DEPTH):0]   o_fifo_count,
  output logic                     o_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, DRAIN} state_e;

  state_e          state_q;
  logic [1:0]      timer_q;
  logic [7:0]      tx_data_q;
  logic            tx_start_q;
  logic            overflow_q;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [7:0]      mem_q [DEPTH];
  logic [7:0]      conv_d;
  logic            full, empty, push, pop, launch_fifo;

  // Mode bit 0 folds lowercase to upper, bit 1 folds uppercase to lower.
  always_comb begin
    conv_d = i_rx_data;
    if (i_mode[0] && i_rx_data >= 8'h61 && i_rx_data <= 8'h7A)
      conv_d = i_rx_data - 8'h20;
    else if (i_mode[1] && i_rx_data >= 8'h41 && i_rx_data <= 8'h5A)
      conv_d = i_rx_data + 8'h20;
  end

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = i_rx_valid && !full;

`ifdef CASE_CONV_CRLF_EN
  logic lf_pending_q;
  logic launch_lf;
  assign launch_lf   = (state_q == IDLE) && !i_tx_busy && lf_pending_q;
  assign launch_fifo = (state_q == IDLE) && !i_tx_busy && !empty && !lf_pending_q;
`else
  assign launch_fifo = (state_q == IDLE) && !i_tx_busy && !empty;
`endif
  assign pop = launch_fifo;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= conv_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      // A drop in the same cycle as a clear leaves the flag set.
      if (i_rx_valid && full) overflow_q <= 1'b1;
      else if (i_clr_ovf)     overflow_q <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      tx_data_q    <= 8'h00;
      tx_start_q   <= 1'b0;
`ifdef CASE_CONV_CRLF_EN
      lf_pending_q <= 1'b0;
`endif
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
`ifdef CASE_CONV_CRLF_EN
          if (launch_lf) begin
            tx_data_q    <= 8'h0A;
            tx_start_q   <= 1'b1;
            lf_pending_q <= 1'b0;
            timer_q      <= '0;
            state_q      <= LAUNCH;
          end else
`endif
          if (launch_fifo) begin
            tx_data_q  <= mem_q[rd_ptr_q];
            tx_start_q <= 1'b1;
            timer_q    <= '0;
            state_q    <= LAUNCH;
`ifdef CASE_CONV_CRLF_EN
            if (mem_q[rd_ptr_q] == 8'h0D) lf_pending_q <= 1'b1;
`endif
          end
        end
        LAUNCH: begin
          // No busy within four cycles means the transmitter took the byte silently.
          if (i_tx_busy)            state_q <= DRAIN;
          else if (timer_q == 2'd3) state_q <= IDLE;
          else                      timer_q <= timer_q + 1'b1;
        end
        DRAIN: begin
          if (!i_tx_busy) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_tx_data    = tx_data_q;
  assign o_tx_start   = tx_start_q;
  assign o_fifo_count = count_q;
  assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_case_conv_ctrl.sv
// tb/tb_case_conv_ctrl.sv - scoreboard bench for case_conv_ctrl (DEPTH=4).
module tb_case_conv_ctrl;

  localparam int DEPTH = 4;
  localparam int BUSY_AUTO  = 0;
  localparam int BUSY_HOLD  = 1;
  localparam int BUSY_NEVER = 2;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic [7:0] i_rx_data;
  logic       i_rx_valid;
  logic [1:0] i_mode;
  logic       i_tx_busy;
  logic       i_clr_ovf;
  logic [7:0] o_tx_data;
  logic       o_tx_start;
  logic [$clog2(DEPTH):0] o_fifo_count;
  logic       o_overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_mode = BUSY_AUTO;
  int busy_len = 3;
  int busy_cnt = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs_data[$];
  int         obs_cyc[$];

  case_conv_ctrl #(.DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .i_mode(i_mode), .i_tx_busy(i_tx_busy), .i_clr_ovf(i_clr_ovf),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .o_fifo_count(o_fifo_count),
    .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(negedge i_clk);
      if (i_rst_n && o_tx_start) begin
        obs_data.push_back(o_tx_data);
        obs_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    i_tx_busy = 1'b0;
    forever begin
      @(posedge i_clk); #1;
      case (busy_mode)
        BUSY_HOLD:  i_tx_busy = 1'b1;
        BUSY_NEVER: begin i_tx_busy = 1'b0; busy_cnt = 0; end
        default: begin
          if (o_tx_start) begin
            i_tx_busy = 1'b1;
            busy_cnt = busy_len;
          end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) i_tx_busy = 1'b0;
          end else begin
            i_tx_busy = 1'b0;
          end
        end
      endcase
    end
  end

  function automatic logic [7:0] model(input logic [7:0] b, input logic [1:0] m);
    logic is_lower, is_upper;
    is_lower = (b >= "a") && (b <= "z");
    is_upper = (b >= "A") && (b <= "Z");
    case (m)
      2'b01:   return is_lower ? b - 8'd32 : b;
      2'b10:   return is_upper ? b + 8'd32 : b;
      2'b11:   return is_lower ? b - 8'd32 : (is_upper ? b + 8'd32 : b);
      default: return b;
    endcase
  endfunction

  task automatic send(input logic [7:0] b, input bit expect_it, input bit clr, output int at_cyc);
    @(posedge i_clk); #1;
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    i_clr_ovf  = clr;
    at_cyc     = cyc;
    if (expect_it) exp_q.push_back(model(b, i_mode));
    @(posedge i_clk); #1;
    i_rx_valid = 1'b0;
    i_clr_ovf  = 1'b0;
  endtask

  task automatic wait_obs(output bit got);
    got = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (obs_data.size() > 0) begin
        got = 1'b1;
        break;
      end
      @(posedge i_clk);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0; i_rx_data = 8'h00; i_rx_valid = 1'b0; i_mode = 2'b00; i_clr_ovf = 1'b0;
    idle_cycles(3);
    checks++;
    if ({o_tx_data, o_tx_start, o_fifo_count, o_overflow} !== '0) begin
      errors++;
      $display("FAIL reset_outputs data=%h start=%b count=%0d ovf=%b required all 0",
               o_tx_data, o_tx_start, o_fifo_count, o_overflow);
    end
    i_rst_n = 1'b1;
    idle_cycles(2);
  endtask

  task automatic test_upper_latency;
    int t0; bit got; logic [7:0] e;
    i_mode = 2'b01; busy_mode = BUSY_AUTO; busy_len = 3;
    send(8'h61, 1'b1, 1'b0, t0);
    wait_obs(got);
    checks++;
    if (!got) begin errors++; $display("FAIL upper_timeout no o_tx_start seen"); return; end
    e = exp_q.pop_front();
    checks++;
    if (obs_data[0] !== e || e !== 8'h41) begin
      errors++; $display("FAIL upper_data got=%h required=41", obs_data[0]);
    end
    checks++;
    if (obs_cyc[0] !== t0 + 2) begin
      errors++; $display("FAIL upper_latency got=%0d required=2", obs_cyc[0] - t0);
    end
    void'(obs_data.pop_front()); void'(obs_cyc.pop_front());
    idle_cycles(12);
  endtask

  task automatic test_toggle;
    int t0; bit got; logic [7:0] e;
    i_mode = 2'b11; busy_mode = BUSY_AUTO; busy_len = 3;
    send(8'h41, 1'b1, 1'b0, t0);
    send(8'h7A, 1'b1, 1'b0, t0);
    send(8'h35, 1'b1, 1'b0, t0);
    for (int k = 0; k < 3; k++) begin
      wait_obs(got);
      checks++;
      if (!got) begin errors++; $display("FAIL toggle_timeout byte %0d", k); break; end
      e = exp_q.pop_front();
      checks++;
      if (obs_data[0] !== e) begin
        errors++; $display("FAIL toggle_byte%0d got=%h required=%h", k, obs_data[0], e);
      end
      void'(obs_data.pop_front()); void'(obs_cyc.pop_front());
    end
    exp_q.delete();
    idle_cycles(12);
  endtask

  task automatic test_overflow;
    int t0; bit got; logic [7:0] e;
    i_mode = 2'b00; busy_mode = BUSY_HOLD;
    idle_cycles(2);
    for (int k = 0; k < 5; k++) send(8'h10 + 8'(k), k < 4, 1'b0, t0);
    checks++;
    if (o_fifo_count !== 3'd4) begin
      errors++; $display("FAIL ovf_count got=%0d required=4", o_fifo_count);
    end
    checks++;
    if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b required=1", o_overflow); end
    send(8'h20, 1'b0, 1'b1, t0);
    checks++;
    if (o_overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_set_beats_clear got=%b required=1", o_overflow);
    end
    @(posedge i_clk); #1; i_clr_ovf = 1'b1;
    @(posedge i_clk); #1; i_clr_ovf = 1'b0;
    checks++;
    if (o_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b required=0", o_overflow); end
    busy_mode = BUSY_AUTO; busy_len = 3;
    for (int k = 0; k < 4; k++) begin
      wait_obs(got);
      checks++;
      if (!got) begin errors++; $display("FAIL ovf_drain_timeout byte %0d", k); break; end
      e = exp_q.pop_front();
      checks++;
      if (obs_data[0] !== e) begin
        errors++; $display("FAIL ovf_drain%0d got=%h required=%h", k, obs_data[0], e);
      end
      void'(obs_data.pop_front()); void'(obs_cyc.pop_front());
    end
    exp_q.delete();
    idle_cycles(30);
    checks++;
    if (obs_data.size() != 0) begin
      errors++; $display("FAIL ovf_dropped_sent extra=%0d required=0", obs_data.size());
    end
    obs_data.delete(); obs_cyc.delete();
  endtask

  task automatic test_timeout;
    int t0; bit got;
    i_mode = 2'b00; busy_mode = BUSY_NEVER;
    send(8'h51, 1'b1, 1'b0, t0);
    send(8'h52, 1'b1, 1'b0, t0);
    for (int k = 0; k < 2; k++) begin
      wait_obs(got);
      checks++;
      if (!got) begin errors++; $display("FAIL timeout_stall byte %0d", k); return; end
      if (k == 0) wait (obs_data.size() > 1 || cyc > obs_cyc[0] + 20);
    end
    checks++;
    if (obs_data.size() < 2) begin
      errors++; $display("FAIL timeout_second_launch seen=%0d required=2", obs_data.size());
    end else begin
      checks++;
      if (obs_data[0] !== exp_q[0] || obs_data[1] !== exp_q[1]) begin
        errors++; $display("FAIL timeout_data got=%h,%h required=%h,%h",
                           obs_data[0], obs_data[1], exp_q[0], exp_q[1]);
      end
      checks++;
      if (obs_cyc[1] - obs_cyc[0] !== 5) begin
        errors++; $display("FAIL timeout_gap got=%0d required=5", obs_cyc[1] - obs_cyc[0]);
      end
    end
    exp_q.delete(); obs_data.delete(); obs_cyc.delete();
    idle_cycles(12);
  endtask

  task automatic test_crlf;
    int t0; bit got; logic [7:0] e; int n;
    i_mode = 2'b00; busy_mode = BUSY_AUTO; busy_len = 3;
    send(8'h0D, 1'b1, 1'b0, t0);
`ifdef CASE_CONV_CRLF_EN
    exp_q.push_back(8'h0A);
`endif
    send(8'h42, 1'b1, 1'b0, t0);
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      wait_obs(got);
      checks++;
      if (!got) begin errors++; $display("FAIL crlf_timeout byte %0d", k); break; end
      e = exp_q.pop_front();
      checks++;
      if (obs_data[0] !== e) begin
        errors++; $display("FAIL crlf_byte%0d got=%h required=%h", k, obs_data[0], e);
      end
      void'(obs_data.pop_front()); void'(obs_cyc.pop_front());
    end
    exp_q.delete();
    idle_cycles(20);
    checks++;
    if (obs_data.size() != 0) begin
      errors++; $display("FAIL crlf_extra got=%h required=none", obs_data[0]);
    end
    obs_data.delete(); obs_cyc.delete();
  endtask

  task automatic test_reset_mid_drain;
    int t0; bit got; logic [7:0] e;
    i_mode = 2'b00; busy_mode = BUSY_AUTO; busy_len = 40;
    for (int k = 0; k < 4; k++) send(8'h61 + 8'(k), k == 0, 1'b0, t0);
    checks++;
    if (o_fifo_count !== 3'd3) begin
      errors++; $display("FAIL mid_count got=%0d required=3", o_fifo_count);
    end
    wait_obs(got);
    checks++;
    if (!got || obs_data[0] !== exp_q[0]) begin
      errors++; $display("FAIL mid_first_byte got=%h required=%h", got ? obs_data[0] : 8'hxx, exp_q[0]);
    end
    exp_q.delete(); obs_data.delete(); obs_cyc.delete();
    @(posedge i_clk); #1; i_rst_n = 1'b0;
    #1;
    checks++;
    if ({o_tx_data, o_tx_start, o_fifo_count, o_overflow} !== '0) begin
      errors++; $display("FAIL mid_reset_outputs data=%h start=%b count=%0d ovf=%b required all 0",
                         o_tx_data, o_tx_start, o_fifo_count, o_overflow);
    end
    busy_mode = BUSY_NEVER;
    idle_cycles(2);
    i_rst_n = 1'b1;
    idle_cycles(25);
    checks++;
    if (obs_data.size() != 0 || o_fifo_count !== '0) begin
      errors++; $display("FAIL mid_post_release starts=%0d count=%0d required 0,0",
                         obs_data.size(), o_fifo_count);
    end
    obs_data.delete(); obs_cyc.delete();
    send(8'h33, 1'b1, 1'b0, t0);
    wait_obs(got);
    checks++;
    if (!got) begin
      errors++; $display("FAIL mid_new_data_timeout");
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (obs_data[0] !== e) begin errors++; $display("FAIL mid_new_data got=%h required=%h", obs_data[0], e); end
    end
    exp_q.delete(); obs_data.delete(); obs_cyc.delete();
    idle_cycles(10);
  endtask

  initial begin
    test_reset();
    test_upper_latency();
    test_toggle();
    test_overflow();
    test_timeout();
    test_crlf();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/case_conv_ctrl.md
CASE_CONV_CTRL -- requirements
Module: case_conv_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, the FIFO depth in bytes; legal values are powers of 2 from 2 to 16.
REQ-002 SHALL have port i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port i_rx_data  input  8  received byte from the UART receiver.
REQ-005 SHALL have port i_rx_valid  input  1  single-cycle pulse qualifying i_rx_data.
REQ-006 SHALL have port i_mode  input  2  conversion mode: 00 pass, 01 upper, 10 lower, 11 toggle.
REQ-007 SHALL have port i_tx_busy  input  1  transmitter busy flag.
REQ-008 SHALL have port i_clr_ovf  input  1  clears o_overflow.
REQ-009 SHALL have port o_tx_data  output  8  byte presented to the transmitter; held stable from the o_tx_start cycle until the FSM returns to IDLE.
REQ-010 SHALL have port o_tx_start  output  1  registered single-cycle transmit request.
REQ-011 SHALL have port o_fifo_count  output  $clog2(DEPTH)+1  number of bytes currently stored.
REQ-012 SHALL have port o_overflow  output  1  sticky flag for a dropped received byte.

Function
REQ-013 SHALL apply conversion at FIFO write time, using i_mode sampled in the i_rx_valid cycle.
REQ-014 SHALL convert as follows: upper maps 0x61-0x7A to value-0x20; lower maps 0x41-0x5A to value+0x20; toggle applies both mappings; all other bytes and pass mode leave the byte unchanged.
REQ-015 SHALL push the converted byte when i_rx_valid=1 and o_fifo_count<DEPTH, measured at the start of the cycle.
REQ-016 SHALL drop the byte and set o_overflow=1 when i_rx_valid=1 and the FIFO is full, even if a pop occurs in the same cycle.
REQ-017 SHALL update o_fifo_count by +1 on push only, -1 on pop only, and leave it unchanged on a simultaneous push and pop; read/write pointers wrap modulo DEPTH.
REQ-018 SHALL implement the TX FSM with states IDLE, LAUNCH and DRAIN.
REQ-019 SHALL, in IDLE with FIFO non-empty and i_tx_busy=0, pop the head into o_tx_data, pulse o_tx_start for one cycle and move to LAUNCH.
REQ-020 SHALL, in LAUNCH, move to DRAIN when i_tx_busy=1, or return to IDLE after 4 cycles without i_tx_busy=1 (timeout; the byte is considered sent).
REQ-021 SHALL, in DRAIN, return to IDLE when i_tx_busy=0.
REQ-022 SHALL assert o_tx_start exactly 2 cycles after an i_rx_valid pulse that arrives with the FIFO empty, the FSM in IDLE and i_tx_busy=0.
REQ-023 SHALL never assert o_tx_start outside IDLE, and never while i_tx_busy=1.
REQ-024 SHALL clear o_overflow when i_clr_ovf=1, except that a set event in the same cycle wins.

Reset
REQ-025 SHALL, while i_rst_n=0, force: o_tx_data=0x00, o_tx_start=0, o_fifo_count=0, o_overflow=0, FSM=IDLE, pointers=0 and the pending-LF flag=0.
REQ-026 SHALL, on reset mid-transfer, discard stored bytes and any pending LF, and issue no further o_tx_start until new data is received after reset release.

Configuration
REQ-027 SHALL, with CASE_CONV_CRLF_EN defined, set a pending-LF flag whenever 0x0D is launched; on return to IDLE with the flag set, launch 0x0A (no FIFO pop, same LAUNCH/DRAIN sequence) before any FIFO byte, then clear the flag.
REQ-028 SHALL, without CASE_CONV_CRLF_EN, transmit 0x0D alone and contain no pending-LF logic.

Verification
REQ-029 SHALL cover: mode=01, rx 0x61 with tx idle -> o_tx_start 2 cycles later, o_tx_data=0x41.
REQ-030 SHALL cover: mode=11, rx 0x41,0x7A,0x35 -> transmitted 0x61,0x5A,0x35 in order, each after busy falls.
REQ-031 SHALL cover: i_tx_busy held 1, DEPTH=4, 5 rx bytes -> o_fifo_count=4, o_overflow=1, 5th byte never transmitted; i_clr_ovf clears the flag.
REQ-032 SHALL cover: i_tx_busy never rises after o_tx_start -> FSM returns to IDLE after 4 cycles and the next byte launches.
REQ-033 SHALL cover: with CASE_CONV_CRLF_EN, rx 0x0D,0x42 in pass mode -> transmitted 0x0D,0x0A,0x42; without the macro -> 0x0D,0x42.
REQ-034 SHALL cover: i_rst_n low during DRAIN with 3 bytes queued -> all outputs 0 and no o_tx_start after release.
